vga_timing_gen: RTL and testbench

- Source end of the video timing bus consumed by the sprite/rectangle draw stages: hcount, vcount, hsync, vsync, hblnk, vblnk and visible.
- Generates raster timing from pixel-clock counters. Default mode is 800x600@60 Hz at a 40 MHz pclk.
- Also emits frame_ended, a single-cycle end-of-frame strobe. Downstream stages delay it in step with their pipelines and use it to latch per-frame positions.

---
 rtl/vga_pkg.sv | 23 ++
 rtl/vga_timing_gen_timing_axis.sv | 54 +++++
 rtl/vga_timing_gen.sv | 70 +++++++
 tb/tb_vga_timing_gen.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared raster timing constants for the 800x600@60 Hz (40 MHz pclk) mode,
// used by the timing generator and by the downstream draw stages.
package vga_pkg;

  localparam int CNT_W     = 11;
  localparam int MAX_TOTAL = 2048;

  localparam int VGA_H_VISIBLE = 800;
  localparam int VGA_H_FRONT   = 40;
  localparam int VGA_H_SYNC    = 128;
  localparam int VGA_H_BACK    = 88;
  localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

  localparam int VGA_V_VISIBLE = 600;
  localparam int VGA_V_FRONT   = 1;
  localparam int VGA_V_SYNC    = 4;
  localparam int VGA_V_BACK    = 23;
  localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  localparam logic VGA_HSYNC_POL = 1'b1;
  localparam logic VGA_VSYNC_POL = 1'b1;

endpackage

// File: rtl/vga_timing_gen_timing_axis.sv
// One raster axis: wrapping position counter with enable, plus blank/sync
// flags registered from the next count so they line up with the count.
module timing_axis
  import vga_pkg::*;
#(
  parameter int   VISIBLE  = VGA_H_VISIBLE,
  parameter int   FRONT    = VGA_H_FRONT,
  parameter int   SYNC     = VGA_H_SYNC,
  parameter int   BACK     = VGA_H_BACK,
  parameter logic SYNC_POL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             blnk,
  output logic             sync,
  output logic             wrap,
  output logic             next_last,
  output logic             next_blnk
);

  localparam int TOTAL = VISIBLE + FRONT + SYNC + BACK;
  localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] VIS_END    = CNT_W'(VISIBLE);
  localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(VISIBLE + FRONT);
  localparam logic [CNT_W-1:0] SYNC_END   = CNT_W'(VISIBLE + FRONT + SYNC);

  logic [CNT_W-1:0] nxt;
  logic             next_sync;

  always_comb begin
    nxt = count;
    if (en) nxt = (count == LAST) ? '0 : count + CNT_W'(1);
  end

  assign wrap      = en & (count == LAST);
  assign next_last = (nxt == LAST);
  assign next_blnk = (nxt >= VIS_END);
  assign next_sync = (nxt >= SYNC_START) && (nxt < SYNC_END);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      blnk  <= 1'b0;
      sync  <= ~SYNC_POL;
    end else begin
      count <= nxt;
      blnk  <= next_blnk;
      sync  <= next_sync ? SYNC_POL : ~SYNC_POL;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: pixel/line counters, blank/sync flags, visible and a
// one-cycle end-of-frame strobe, all registered and aligned to the counts.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_VISIBLE = VGA_H_VISIBLE,
  parameter int   H_FRONT   = VGA_H_FRONT,
  parameter int   H_SYNC    = VGA_H_SYNC,
  parameter int   H_BACK    = VGA_H_BACK,
  parameter int   V_VISIBLE = VGA_V_VISIBLE,
  parameter int   V_FRONT   = VGA_V_FRONT,
  parameter int   V_SYNC    = VGA_V_SYNC,
  parameter int   V_BACK    = VGA_V_BACK,
  parameter logic HSYNC_POL = VGA_HSYNC_POL,
  parameter logic VSYNC_POL = VGA_VSYNC_POL
) (
  input  logic             pclk,
  input  logic             rst,
  output logic [CNT_W-1:0] hcount_out,
  output logic             hsync_out,
  output logic             hblnk_out,
  output logic [CNT_W-1:0] vcount_out,
  output logic             vsync_out,
  output logic             vblnk_out,
  output logic             visible_out,
  output logic             frame_ended_out
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL ||
      H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
      V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0) begin : g_bad_timing
    $error("vga_timing_gen: totals must be <= 2048 and porch/sync widths nonzero");
  end

  logic h_wrap, h_next_last, h_next_blnk;
  logic v_wrap_unused, v_next_last, v_next_blnk;

  timing_axis #(
    .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK),
    .SYNC_POL(HSYNC_POL)
  ) u_h (
    .clk(pclk), .rst(rst), .en(1'b1),
    .count(hcount_out), .blnk(hblnk_out), .sync(hsync_out),
    .wrap(h_wrap), .next_last(h_next_last), .next_blnk(h_next_blnk)
  );

  // Lines advance only on the cycle the pixel counter wraps.
  timing_axis #(
    .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK),
    .SYNC_POL(VSYNC_POL)
  ) u_v (
    .clk(pclk), .rst(rst), .en(h_wrap),
    .count(vcount_out), .blnk(vblnk_out), .sync(vsync_out),
    .wrap(v_wrap_unused), .next_last(v_next_last), .next_blnk(v_next_blnk)
  );

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      visible_out     <= 1'b1;
      frame_ended_out <= 1'b0;
    end else begin
      visible_out     <= ~h_next_blnk & ~v_next_blnk;
      frame_ended_out <= h_next_last & v_next_last;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a reduced raster (25x16) in both sync polarities,
// checked every cycle against an arithmetic position model plus a vector table.
module tb_vga_timing_gen;

  localparam int HV = 16, HF = 2, HS = 4, HB = 3;
  localparam int VV = 10, VF = 1, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;   // 25
  localparam int VT = VV + VF + VS + VB;   // 16
  localparam int FRAME = HT * VT;          // 400

  logic pclk, rst;
  logic [10:0] hcount_a, vcount_a, hcount_b, vcount_b;
  logic hsync_a, hblnk_a, vsync_a, vblnk_a, visible_a, fe_a;
  logic hsync_b, hblnk_b, vsync_b, vblnk_b, visible_b, fe_b;

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) dut_a (
    .pclk(pclk), .rst(rst),
    .hcount_out(hcount_a), .hsync_out(hsync_a), .hblnk_out(hblnk_a),
    .vcount_out(vcount_a), .vsync_out(vsync_a), .vblnk_out(vblnk_a),
    .visible_out(visible_a), .frame_ended_out(fe_a)
  );

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut_b (
    .pclk(pclk), .rst(rst),
    .hcount_out(hcount_b), .hsync_out(hsync_b), .hblnk_out(hblnk_b),
    .vcount_out(vcount_b), .vsync_out(vsync_b), .vblnk_out(vblnk_b),
    .visible_out(visible_b), .frame_ended_out(fe_b)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    int   n;
    int   h;
    int   v;
    logic hb, hs, vb, vs, vis, fe;
  } vec_t;

  localparam int NT = 18;
  vec_t tbl[NT];

  int  total = 0;
  int  bad   = 0;
  int  n     = 0;   // rising edges since reset release
  int  k     = 0;
  bit  tbl_on = 1'b0;

  // Position after n edges is plain division of the elapsed pixel count.
  function automatic logic [27:0] model(input int cyc, input bit pol);
    int h, v;
    logic hb, hs, vb, vs;
    h  = cyc % HT;
    v  = (cyc / HT) % VT;
    hb = (h >= HV);
    vb = (v >= VV);
    hs = (h >= HV + HF && h < HV + HF + HS) ? pol : !pol;
    vs = (v >= VV + VF && v < VV + VF + VS) ? pol : !pol;
    return {11'(h), 11'(v), hb, hs, vb, vs, !hb && !vb, (h == HT - 1) && (v == VT - 1)};
  endfunction

  task automatic cmp(input string name, input logic [27:0] got, input logic [27:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s n=%0d got=%h want=%h", name, n, got, want);
    end
  endtask

  task automatic check_cur();
    logic [27:0] ga, gb, et;
    ga = {hcount_a, vcount_a, hblnk_a, hsync_a, vblnk_a, vsync_a, visible_a, fe_a};
    gb = {hcount_b, vcount_b, hblnk_b, hsync_b, vblnk_b, vsync_b, visible_b, fe_b};
    cmp("pos_pol_model", ga, model(n, 1'b1));
    cmp("neg_pol_model", gb, model(n, 1'b0));
    cmp("visible_rule", {27'b0, visible_a}, {27'b0, ~hblnk_a & ~vblnk_a});
    if (tbl_on && k < NT && tbl[k].n == n) begin
      et = {11'(tbl[k].h), 11'(tbl[k].v), tbl[k].hb, tbl[k].hs, tbl[k].vb, tbl[k].vs,
            tbl[k].vis, tbl[k].fe};
      cmp("table", ga, et);
      k++;
    end
  endtask

  task automatic step();
    @(negedge pclk);
    n++;
    check_cur();
  endtask

  // Called mid-cycle (at a falling edge): reset must act with no clock edge.
  task automatic do_reset(input int hold);
    #2 rst = 1'b1;
    n = 0;
    #1 check_cur();
    repeat (hold) @(posedge pclk);
    @(negedge pclk);
    rst = 1'b0;
    #1 check_cur();
  endtask

  task automatic run_to_fe(output int steps, output bit ok);
    steps = 0;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      step();
      steps++;
      if (fe_a) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int  s;
    bit  ok;
    tbl[0]  = '{0,   0,  0,  0, 0, 0, 0, 1, 0};
    tbl[1]  = '{1,   1,  0,  0, 0, 0, 0, 1, 0};
    tbl[2]  = '{15,  15, 0,  0, 0, 0, 0, 1, 0};
    tbl[3]  = '{16,  16, 0,  1, 0, 0, 0, 0, 0};
    tbl[4]  = '{17,  17, 0,  1, 0, 0, 0, 0, 0};
    tbl[5]  = '{18,  18, 0,  1, 1, 0, 0, 0, 0};
    tbl[6]  = '{21,  21, 0,  1, 1, 0, 0, 0, 0};
    tbl[7]  = '{22,  22, 0,  1, 0, 0, 0, 0, 0};
    tbl[8]  = '{24,  24, 0,  1, 0, 0, 0, 0, 0};
    tbl[9]  = '{25,  0,  1,  0, 0, 0, 0, 1, 0};
    tbl[10] = '{250, 0,  10, 0, 0, 1, 0, 0, 0};
    tbl[11] = '{274, 24, 10, 1, 0, 1, 0, 0, 0};
    tbl[12] = '{275, 0,  11, 0, 0, 1, 1, 0, 0};
    tbl[13] = '{324, 24, 12, 1, 0, 1, 1, 0, 0};
    tbl[14] = '{325, 0,  13, 0, 0, 1, 0, 0, 0};
    tbl[15] = '{399, 24, 15, 1, 0, 1, 0, 0, 1};
    tbl[16] = '{400, 0,  0,  0, 0, 0, 0, 1, 0};
    tbl[17] = '{799, 24, 15, 1, 0, 1, 0, 0, 1};

    rst = 1'b1;
    #12 check_cur();
    @(negedge pclk);
    rst = 1'b0;
    n = 0;
    tbl_on = 1'b1;
    #1 check_cur();
    repeat (2 * FRAME) step();
    tbl_on = 1'b0;
    cmp("table_entries_hit", 28'(k), 28'(NT));

    run_to_fe(s, ok);
    cmp("fe_found_1", {27'b0, ok}, 28'd1);
    cmp("fe_first_gap", 28'(s), 28'(FRAME - 1));
    run_to_fe(s, ok);
    cmp("fe_found_2", {27'b0, ok}, 28'd1);
    cmp("fe_period", 28'(s), 28'(FRAME));

    repeat (4) begin
      repeat ($urandom_range(1, 450)) step();
      do_reset($urandom_range(1, 4));
    end

    // Reset mid-frame at h=12, v=7 for three cycles.
    for (int i = 0; i < 1000 && (n % FRAME) != 7 * HT + 12; i++) step();
    cmp("reach_mid_frame", 28'(n % FRAME), 28'(7 * HT + 12));
    do_reset(3);
    run_to_fe(s, ok);
    cmp("fe_found_3", {27'b0, ok}, 28'd1);
    cmp("fe_after_reset", 28'(s), 28'(FRAME - 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
